// File: rtl/glitchless_clock_mux.sv
// Two-input selector for low-rate clock-like signals, sampled by CLK.
// In SYNC mode a switchover parks O at IDLE_LEVEL so no runt pulse reaches O.
module glitchless_clock_mux #(
    parameter string CLK_SEL_TYPE = "SYNC",
    parameter int    IDLE_LEVEL   = 0,
    parameter int    SEL_INVERT   = 0
) (
    input  logic CLK,
    input  logic RST,
    input  logic I0,
    input  logic I1,
    input  logic S,
    output logic O,
    output logic SEL_CUR,
    output logic SWITCHING
);

    localparam bit IS_SYNC  = (CLK_SEL_TYPE == "SYNC");
    localparam bit IS_ASYNC = (CLK_SEL_TYPE == "ASYNC");

    // Attribute errors stop elaboration before any simulation time passes.
    if (!(IS_SYNC || IS_ASYNC)) begin : g_bad_sel_type
        $fatal(1, "%m: attribute error, CLK_SEL_TYPE must be \"SYNC\" or \"ASYNC\"");
    end
    if (IDLE_LEVEL < 0 || IDLE_LEVEL > 1) begin : g_bad_idle_level
        $fatal(1, "%m: attribute error, IDLE_LEVEL must be 0 or 1");
    end
    if (SEL_INVERT < 0 || SEL_INVERT > 1) begin : g_bad_sel_invert
        $fatal(1, "%m: attribute error, SEL_INVERT must be 0 or 1");
    end

    localparam logic IDLE = IDLE_LEVEL[0];
    localparam logic INV  = SEL_INVERT[0];

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_WAIT_OLD = 2'd1;
    localparam logic [1:0] ST_WAIT_NEW = 2'd2;

    logic [1:0] state_q, state_d;
    logic       cur_q, cur_d;
    logic       o_q, o_d;

    logic s_eff;
    logic i_cur;
    logic i_oth;

    assign s_eff = S ^ INV;
    assign i_cur = cur_q ? I1 : I0;
    assign i_oth = cur_q ? I0 : I1;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        o_d     = o_q;
        case (state_q)
            ST_RUN: begin
                o_d = i_cur;
                if (s_eff != cur_q) begin
                    if (IS_SYNC) begin
                        state_d = ST_WAIT_OLD;
                    end else begin
                        cur_d = s_eff;
                        o_d   = i_oth;
                    end
                end
            end
            ST_WAIT_OLD: begin
                if (s_eff == cur_q) begin
                    state_d = ST_RUN;
                    o_d     = i_cur;
                end else if (i_cur == IDLE) begin
                    o_d     = IDLE;
                    cur_d   = ~cur_q;
                    state_d = ST_WAIT_NEW;
                end else begin
                    o_d = i_cur;
                end
            end
            ST_WAIT_NEW: begin
                // O is already parked here, so a new target can be taken freely.
                o_d = IDLE;
                if (s_eff != cur_q) begin
                    cur_d = s_eff;
                end else if (i_cur == IDLE) begin
                    state_d = ST_RUN;
                    o_d     = i_cur;
                end
            end
            default: begin
                state_d = ST_RUN;
                o_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_RUN;
            cur_q   <= 1'b0;
            o_q     <= IDLE;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            o_q     <= o_d;
        end
    end

    assign O         = o_q;
    assign SEL_CUR   = cur_q;
    assign SWITCHING = (state_q != ST_RUN);

endmodule

// File: tb/tb_glitchless_clock_mux.sv
// Directed bench for three mux variants: SYNC idle-low, ASYNC idle-low,
// SYNC idle-high with select inverter. Expected {O,SEL_CUR,SWITCHING} per edge.
module tb_glitchless_clock_mux;

    logic clk;
    logic rst_0, i0_0, i1_0, s_0, o_0, sel_0, sw_0;
    logic rst_1, i0_1, i1_1, s_1, o_1, sel_1, sw_1;
    logic rst_2, i0_2, i1_2, s_2, o_2, sel_2, sw_2;

    int checks = 0;
    int errors = 0;
    int popped = 0;

    logic [4:0] exp_q[$];
    logic [4:0] ent;

    glitchless_clock_mux #(.CLK_SEL_TYPE("SYNC"), .IDLE_LEVEL(0), .SEL_INVERT(0)) u_sync (
        .CLK(clk), .RST(rst_0), .I0(i0_0), .I1(i1_0), .S(s_0),
        .O(o_0), .SEL_CUR(sel_0), .SWITCHING(sw_0)
    );

    glitchless_clock_mux #(.CLK_SEL_TYPE("ASYNC"), .IDLE_LEVEL(0), .SEL_INVERT(0)) u_async (
        .CLK(clk), .RST(rst_1), .I0(i0_1), .I1(i1_1), .S(s_1),
        .O(o_1), .SEL_CUR(sel_1), .SWITCHING(sw_1)
    );

    glitchless_clock_mux #(.CLK_SEL_TYPE("SYNC"), .IDLE_LEVEL(1), .SEL_INVERT(1)) u_idle_hi (
        .CLK(clk), .RST(rst_2), .I0(i0_2), .I1(i1_2), .S(s_2),
        .O(o_2), .SEL_CUR(sel_2), .SWITCHING(sw_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [1:0] id, input logic [2:0] e, input string name);
        logic [2:0] act;
        case (id)
            2'd0:    act = {o_0, sel_0, sw_0};
            2'd1:    act = {o_1, sel_1, sw_1};
            default: act = {o_2, sel_2, sw_2};
        endcase
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s dut%0d: got o/sel/sw=%b, expected %b", name, id, act, e);
        end
    endtask

    // Drive one edge of stimulus and queue the state expected after that edge.
    task automatic step(input logic [1:0] id, input logic r, input logic a,
                        input logic b, input logic s, input logic [2:0] e);
        @(negedge clk);
        case (id)
            2'd0:    begin rst_0 = r; i0_0 = a; i1_0 = b; s_0 = s; end
            2'd1:    begin rst_1 = r; i0_1 = a; i1_1 = b; s_1 = s; end
            default: begin rst_2 = r; i0_2 = a; i1_2 = b; s_2 = s; end
        endcase
        exp_q.push_back({id, e});
    endtask

    // Asynchronous reset assertion, checked before any clock edge.
    task automatic reset_now(input logic [1:0] id, input logic [2:0] e, input string name);
        @(negedge clk);
        case (id)
            2'd0:    rst_0 = 1'b1;
            2'd1:    rst_1 = 1'b1;
            default: rst_2 = 1'b1;
        endcase
        #1;
        check(id, e, name);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            ent = exp_q.pop_front();
            popped++;
            check(ent[4:3], ent[2:0], $sformatf("edge%0d", popped));
        end
    end

    initial begin
        rst_0 = 1'b1; i0_0 = 1'b1; i1_0 = 1'b0; s_0 = 1'b0;
        rst_1 = 1'b1; i0_1 = 1'b1; i1_1 = 1'b0; s_1 = 1'b0;
        rst_2 = 1'b1; i0_2 = 1'b1; i1_2 = 1'b0; s_2 = 1'b0;
        #1;
        check(2'd0, 3'b000, "reset_sync");
        check(2'd1, 3'b000, "reset_async");
        check(2'd2, 3'b100, "reset_idle_hi");

        // SYNC idle-low: tracking, full switch, abort, retarget
        step(0, 1, 1, 0, 0, 3'b000);
        step(0, 0, 1, 0, 0, 3'b100);
        step(0, 0, 0, 0, 0, 3'b000);
        step(0, 0, 1, 0, 0, 3'b100);
        step(0, 0, 1, 1, 1, 3'b101);
        step(0, 0, 1, 0, 1, 3'b101);
        step(0, 0, 0, 1, 1, 3'b011);
        step(0, 0, 1, 1, 1, 3'b011);
        step(0, 0, 0, 1, 1, 3'b011);
        step(0, 0, 1, 0, 1, 3'b010);
        step(0, 0, 1, 1, 1, 3'b110);
        step(0, 0, 0, 0, 1, 3'b010);
        step(0, 0, 0, 1, 0, 3'b111);
        step(0, 0, 0, 1, 1, 3'b110);
        step(0, 0, 0, 0, 1, 3'b010);
        step(0, 0, 1, 0, 0, 3'b011);
        step(0, 0, 1, 0, 0, 3'b001);
        step(0, 0, 1, 1, 1, 3'b011);
        step(0, 0, 1, 1, 1, 3'b011);
        reset_now(0, 3'b000, "reset_in_wait_new");
        step(0, 0, 1, 0, 0, 3'b100);
        step(0, 0, 0, 0, 1, 3'b001);
        step(0, 0, 0, 0, 1, 3'b011);
        step(0, 0, 0, 0, 1, 3'b010);
        step(0, 0, 0, 1, 1, 3'b110);

        // ASYNC: switch takes effect on the sampling edge
        step(1, 1, 1, 0, 0, 3'b000);
        step(1, 0, 1, 0, 0, 3'b100);
        step(1, 0, 1, 0, 1, 3'b010);
        step(1, 0, 1, 1, 1, 3'b110);
        step(1, 0, 0, 1, 0, 3'b000);
        step(1, 0, 1, 0, 0, 3'b100);

        // Idle-high with inverter: S=0 targets I1 right out of reset
        step(2, 1, 1, 0, 0, 3'b100);
        step(2, 0, 0, 0, 0, 3'b001);
        step(2, 0, 0, 0, 0, 3'b001);
        step(2, 0, 1, 0, 0, 3'b111);
        step(2, 0, 0, 0, 0, 3'b111);
        step(2, 0, 0, 1, 0, 3'b110);
        step(2, 0, 0, 0, 0, 3'b010);
        step(2, 0, 1, 1, 0, 3'b110);
        step(2, 0, 0, 0, 1, 3'b011);
        reset_now(2, 3'b100, "reset_in_wait_old");
        step(2, 1, 1, 0, 1, 3'b100);
        step(2, 0, 1, 0, 1, 3'b100);
        step(2, 0, 0, 0, 1, 3'b000);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
